io_pattern_checker: RTL and testbench
=====================================

Name: io_pattern_checker

Overview:
- Synthesizable user-project block that watches a WIDTH-bit slice of the user GPIO outputs and checks that a programmed sequence of up to DEPTH expected values appears in order.
- Each value must stay stable for STABLE_CYCLES consecutive cycles to count as a match.
- Reports pass, fail or timeout, with progress and cycle-count status, so firmware or the bench reads one verdict instead of waiting on a single literal.
- Sits beside the compute datapath inside the user project wrapper; its inputs are tapped from the mprj_io output drivers.

Parameters:
- WIDTH, 8, bits of observed bus and of each expected entry.
- DEPTH, 4, number of expected-sequence entries (power of 2, >=2).
- STABLE_CYCLES, 1, consecutive equal cycles needed to accept one entry (>=1).
- TIMEOUT_CYCLES, 25000, WAIT-state cycle budget before failing (>=2).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  single-cycle pulse that arms a check run.
- exp_we_i  in  1  write enable for the expected-value table.
- exp_addr_i  in  $clog2(DEPTH)  table write address.
- exp_data_i  in  WIDTH  table write data.
- exp_len_i  in  $clog2(DEPTH)+1  number of entries to check; sampled at start.
- obs_i  in  WIDTH  observed GPIO output slice.
- busy_o  out  1  run in progress.
- pass_o  out  1  sticky: all entries matched.
- fail_o  out  1  sticky: run ended without a full match.
- timeout_o  out  1  sticky: the failure was caused by timeout.
- match_idx_o  out  $clog2(DEPTH)+1  entries matched so far.
- cycles_o  out  32  WAIT cycles elapsed; saturating.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE. The table is not reset; its contents are don't-care until written.
- States: IDLE, WAIT, PASS, FAIL.
- Table writes: exp_we_i takes effect in IDLE, PASS or FAIL. It is ignored in WAIT.
- Arming: start_i in IDLE, PASS or FAIL does the following at that edge:
  - latches len = min(exp_len_i, DEPTH);
  - clears idx, cycles, stable count, pass_o, fail_o, timeout_o;
  - moves to WAIT, with busy_o=1 from the next cycle.
- start_i in WAIT is ignored.
- Zero length: len==0 goes straight from start to PASS. busy_o never rises and pass_o=1 one cycle after start.
- Input register: obs_i is registered once (obs_q); all comparisons use obs_q.
- Matching in WAIT:
  - Each cycle, if obs_q==exp[idx], stable count increments; otherwise it clears to 0.
  - When the count reaches STABLE_CYCLES, idx increments and the count clears.
  - Consecutive equal entries therefore need 2*STABLE_CYCLES cycles.
- Pass: when idx becomes len, go to PASS at that edge; pass_o=1 and busy_o=0.
- Latency: from obs_i showing the final value to pass_o is STABLE_CYCLES+1 cycles.
- Cycle count: cycles_o increments every WAIT cycle and saturates at 2^32-1.
- Timeout: when cycles reaches TIMEOUT_CYCLES-1 with no completion, go to FAIL with fail_o=timeout_o=1.
- Simultaneous final match and timeout in the same cycle: the match wins and the run passes.
- PASS and FAIL hold until start_i or reset. match_idx_o and cycles_o hold their final values.
- Reset mid-run aborts the run immediately; all outputs return to reset values.

Optional Feature:
- Macro: IO_CHECK_MASK_EN.
- Defined:
  - adds port exp_mask_i (in, WIDTH), written alongside exp_data_i into a parallel mask table;
  - mask bit 1 means don't-care, and the compare becomes (obs_q ^ exp) & ~mask == 0.
- Undefined: no mask port and no mask storage; comparison is exact equality.

Decomposition:
- Package io_check_pkg holds:
  - the state enum (IDLE, WAIT, PASS, FAIL);
  - CYC_W=32;
  - the localparam functions for index and length widths.
- One sub-module, io_stability_filter, takes eq and clr and produces an accept pulse once eq has held for STABLE_CYCLES cycles.
- The FSM, table and counters stay in io_pattern_checker.

Test Plan:
- Single entry, WIDTH=8: exp[0]=8'h4f, len=1; obs_i goes 8'h00 then 8'h4f at cycle 10 -> pass_o=1 at cycle 12; match_idx_o=1; fail_o=0.
- Sequence: exp={8'h12,8'h83,8'h4f}, len=3, STABLE_CYCLES=2; drive each value for 2 cycles -> pass. Repeat with 8'h83 held for only 1 cycle -> no advance, match_idx_o stays 1.
- Timeout, TIMEOUT_CYCLES=100: obs_i fixed at 8'hFF -> fail_o=timeout_o=1 with cycles_o=99; a final match in cycle 99 instead -> pass_o=1, timeout_o=0.
- Boundaries:
  - len=0 -> pass_o=1 one cycle after start with busy_o never 1;
  - exp_len_i=7 with DEPTH=4 -> checks 4 entries;
  - exp_we_i during WAIT -> table unchanged.
- Reset and restart: wb_rst_i mid-WAIT -> all outputs 0 next cycle. start_i in WAIT is ignored; start_i in PASS clears flags and reruns.
- IO_CHECK_MASK_EN: exp=8'h40, mask=8'h0F, obs=8'h4f -> pass. Without the macro the same stimulus times out.

Source files
------------

// File: rtl/io_check_pkg.sv
// Shared types and width helpers for the GPIO pattern checker.
package io_check_pkg;

  localparam int CYC_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a full-length run (len == DEPTH) is representable.
  function automatic int len_w(input int depth);
    return idx_w(depth) + 1;
  endfunction

endpackage

// File: rtl/io_stability_filter.sv
// Emits a one-cycle accept once eq has held for STABLE_CYCLES consecutive cycles.
module io_stability_filter #(
  parameter int STABLE_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic eq,
  input  logic clr,
  output logic accept
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  assign accept = eq && !clr && (cnt_r == LAST);

  // Consecutive-equal counter; restarts on mismatch, clear or accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr || !eq || accept) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/io_pattern_checker.sv
// Checks that a programmed sequence of values appears in order on a GPIO slice.
// Optional build macro IO_CHECK_MASK_EN adds a per-entry don't-care mask table.
module io_pattern_checker
  import io_check_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 4,
  parameter int STABLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      start_i,
  input  logic                      exp_we_i,
  input  logic [idx_w(DEPTH)-1:0]   exp_addr_i,
  input  logic [WIDTH-1:0]          exp_data_i,
`ifdef IO_CHECK_MASK_EN
  input  logic [WIDTH-1:0]          exp_mask_i,
`endif
  input  logic [len_w(DEPTH)-1:0]   exp_len_i,
  input  logic [WIDTH-1:0]          obs_i,
  output logic                      busy_o,
  output logic                      pass_o,
  output logic                      fail_o,
  output logic                      timeout_o,
  output logic [len_w(DEPTH)-1:0]   match_idx_o,
  output logic [CYC_W-1:0]          cycles_o
);

  localparam int IW = idx_w(DEPTH);
  localparam int LW = len_w(DEPTH);
  localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

  logic [WIDTH-1:0] exp_mem_r [DEPTH];
`ifdef IO_CHECK_MASK_EN
  logic [WIDTH-1:0] mask_mem_r [DEPTH];
`endif

  state_t           state_r, state_s;
  logic [WIDTH-1:0] obs_q_r;
  logic [LW-1:0]    len_r, len_s, idx_r, idx_s, start_len_s;
  logic [CYC_W-1:0] cyc_r, cyc_s;
  logic             busy_r, busy_s, pass_r, pass_s, fail_r, fail_s, tmo_r, tmo_s;
  logic             eq_s, clr_s, accept_s, last_s, expired_s, arm_s;

  assign start_len_s = (exp_len_i > DEPTH_L) ? DEPTH_L : exp_len_i;
  assign arm_s       = start_i && (state_r != S_WAIT);
  assign clr_s       = (state_r != S_WAIT);
  assign last_s      = accept_s && ((idx_r + LW'(1)) == len_r);
  // A final match in the last budgeted cycle is checked first, so it wins.
  assign expired_s   = (cyc_r >= TO_LAST);

`ifdef IO_CHECK_MASK_EN
  assign eq_s = ((obs_q_r ^ exp_mem_r[idx_r[IW-1:0]]) & ~mask_mem_r[idx_r[IW-1:0]])
                == {WIDTH{1'b0}};
`else
  assign eq_s = (obs_q_r == exp_mem_r[idx_r[IW-1:0]]);
`endif

  io_stability_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clock  (wb_clk_i),
    .reset  (wb_rst_i),
    .eq     (eq_s),
    .clr    (clr_s),
    .accept (accept_s)
  );

  // Expected-value table; frozen while a run is in progress.
  always_ff @(posedge wb_clk_i) begin
    if (exp_we_i && (state_r != S_WAIT)) begin
      exp_mem_r[exp_addr_i]  <= exp_data_i;
`ifdef IO_CHECK_MASK_EN
      mask_mem_r[exp_addr_i] <= exp_mask_i;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start_i) begin
          state_s = (start_len_s == {LW{1'b0}}) ? S_PASS : S_WAIT;
        end else begin
          state_s = state_r;
        end
      end
      S_WAIT: begin
        if (last_s) begin
          state_s = S_PASS;
        end else if (expired_s) begin
          state_s = S_FAIL;
        end else begin
          state_s = S_WAIT;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the counters and status flags.
  always_comb begin
    len_s  = len_r;
    idx_s  = idx_r;
    cyc_s  = cyc_r;
    pass_s = pass_r;
    fail_s = fail_r;
    tmo_s  = tmo_r;
    if (arm_s) begin
      len_s  = start_len_s;
      idx_s  = {LW{1'b0}};
      cyc_s  = {CYC_W{1'b0}};
      pass_s = (start_len_s == {LW{1'b0}});
      fail_s = 1'b0;
      tmo_s  = 1'b0;
    end else if (state_r == S_WAIT) begin
      cyc_s = (cyc_r != CYC_MAX) ? (cyc_r + CYC_W'(1)) : cyc_r;
      idx_s = accept_s ? (idx_r + LW'(1)) : idx_r;
      if (last_s) begin
        pass_s = 1'b1;
      end else if (expired_s) begin
        fail_s = 1'b1;
        tmo_s  = 1'b1;
      end else begin
        pass_s = pass_r;
      end
    end else begin
      idx_s = idx_r;
    end
    busy_s = (state_s == S_WAIT);
  end

  // State, input sample and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= S_IDLE;
      obs_q_r <= {WIDTH{1'b0}};
      len_r   <= {LW{1'b0}};
      idx_r   <= {LW{1'b0}};
      cyc_r   <= {CYC_W{1'b0}};
      busy_r  <= 1'b0;
      pass_r  <= 1'b0;
      fail_r  <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      obs_q_r <= obs_i;
      len_r   <= len_s;
      idx_r   <= idx_s;
      cyc_r   <= cyc_s;
      busy_r  <= busy_s;
      pass_r  <= pass_s;
      fail_r  <= fail_s;
      tmo_r   <= tmo_s;
    end
  end

  assign busy_o      = busy_r;
  assign pass_o      = pass_r;
  assign fail_o      = fail_r;
  assign timeout_o   = tmo_r;
  assign match_idx_o = idx_r;
  assign cycles_o    = cyc_r;

endmodule

// File: tb/tb_io_pattern_checker.sv
// Directed bench for io_pattern_checker (DEPTH=4, STABLE_CYCLES=2, TIMEOUT_CYCLES=100).
module tb_io_pattern_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [7:0]  data = 8'h00;
`ifdef IO_CHECK_MASK_EN
  logic [7:0]  mask = 8'h00;
`endif
  logic [2:0]  len = 3'd0;
  logic [7:0]  obs = 8'h00;
  logic        busy, pass, fail, tmo;
  logic [2:0]  idx;
  logic [31:0] cyc;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  io_pattern_checker #(
    .WIDTH(8), .DEPTH(4), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .exp_we_i(we),
    .exp_addr_i(addr), .exp_data_i(data),
`ifdef IO_CHECK_MASK_EN
    .exp_mask_i(mask),
`endif
    .exp_len_i(len), .obs_i(obs), .busy_o(busy), .pass_o(pass), .fail_o(fail),
    .timeout_o(tmo), .match_idx_o(idx), .cycles_o(cyc)
  );

  typedef struct {
    logic start; logic we; logic [1:0] addr; logic [7:0] data; logic [2:0] len; logic [7:0] obs;
    logic busy; logic pass; logic fail; logic tmo; logic [2:0] idx; logic [31:0] cyc;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic s, input logic w, input logic [1:0] a, input logic [7:0] d,
                              input logic [2:0] l, input logic [7:0] o, input logic b, input logic p,
                              input logic f, input logic t, input logic [2:0] i, input logic [31:0] c);
    vec_t v;
    v.start = s; v.we = w; v.addr = a; v.data = d; v.len = l; v.obs = o;
    v.busy = b; v.pass = p; v.fail = f; v.tmo = t; v.idx = i; v.cyc = c;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic b, input logic p, input logic f,
                         input logic t, input logic [2:0] i, input logic [31:0] c);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".pass"}, {31'd0, pass}, {31'd0, p});
    chk({tag, ".fail"}, {31'd0, fail}, {31'd0, f});
    chk({tag, ".timeout"}, {31'd0, tmo}, {31'd0, t});
    chk({tag, ".idx"}, {29'd0, idx}, {29'd0, i});
    chk({tag, ".cycles"}, cyc, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic [7:0] m);
    we = 1'b1; addr = a; data = d;
`ifdef IO_CHECK_MASK_EN
    mask = m;
`else
    if (m != 8'h00) $display("note: mask %0h dropped in exact-compare build", m);
`endif
    tick();
    we = 1'b0;
`ifdef IO_CHECK_MASK_EN
    mask = 8'h00;
`endif
  endtask

  task automatic arm(input logic [2:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    // Cycle-by-cycle script: load table, full 3-entry run, rerun with a short 83.
    vecs[0]  = mk(1'b0, 1'b1, 2'd0, 8'h12, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    vecs[1]  = mk(1'b0, 1'b1, 2'd1, 8'h83, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    vecs[2]  = mk(1'b0, 1'b1, 2'd2, 8'h4f, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    vecs[3]  = mk(1'b1, 1'b0, 2'd0, 8'h00, 3'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    vecs[4]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1);
    vecs[5]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd2);
    vecs[6]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h83, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd3);
    vecs[7]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h83, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd4);
    vecs[8]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h4f, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'd5);
    vecs[9]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h4f, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'd6);
    vecs[10] = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'd7);
    vecs[11] = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'd7);
    vecs[12] = mk(1'b1, 1'b0, 2'd0, 8'h00, 3'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    vecs[13] = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1);
    vecs[14] = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd2);
    vecs[15] = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h83, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd3);
    vecs[16] = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h4f, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd4);
    vecs[17] = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h4f, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd5);
    vecs[18] = mk(1'b1, 1'b0, 2'd0, 8'h00, 3'd1, 8'h4f, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd6);
    vecs[19] = mk(1'b0, 1'b1, 2'd1, 8'h4f, 3'd0, 8'h4f, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd7);
    vecs[20] = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h4f, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd8);
    vecs[21] = mk(1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 8'h4f, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd9);

    tick();
    do_reset();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);

    for (int i = 0; i < 22; i++) begin
      start = vecs[i].start; we = vecs[i].we; addr = vecs[i].addr;
      data = vecs[i].data; len = vecs[i].len; obs = vecs[i].obs;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].pass, vecs[i].fail,
              vecs[i].tmo, vecs[i].idx, vecs[i].cyc);
    end
    start = 1'b0; we = 1'b0;

    // Reset while a run is in progress.
    do_reset();
    chk_all("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);

    // Timeout: table entry 0 is 8'h12, bus stuck at 8'hFF.
    obs = 8'hFF;
    arm(3'd1);
    n = 0;
    while (!fail && n < 200) begin tick(); n++; end
    chk("timeout.latency", n, 32'd99);
    chk_all("timeout", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'd99);

    // Final match lands in the last budgeted cycle: match wins.
    obs = 8'hFF;
    arm(3'd1);
    repeat (96) tick();
    obs = 8'h12;
    tick(); tick();
    chk_all("late.pre", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd98);
    tick();
    chk_all("late.match", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 32'd99);

    // Zero length: pass next cycle, busy never rises.
    do_reset();
    arm(3'd0);
    chk_all("len0", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    chk("len0.busy_hold", {31'd0, busy}, 32'd0);
    chk("len0.pass_hold", {31'd0, pass}, 32'd1);

    // exp_len_i=7 clamps to 4 entries: 12,83,4f,a5.
    wr(2'd3, 8'ha5, 8'h00);
    obs = 8'h00;
    arm(3'd7);
    obs = 8'h12; tick(); tick();
    obs = 8'h83; tick(); tick();
    obs = 8'h4f; tick(); tick();
    obs = 8'ha5; tick(); tick();
    chk_all("len7.pre", 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'd8);
    tick();
    chk_all("len7.done", 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 32'd9);

    // Single entry 8'h4f appearing on obs_i at cycle 10.
    do_reset();
    wr(2'd0, 8'h4f, 8'h00);
    obs = 8'h00;
    arm(3'd1);
    repeat (9) tick();
    obs = 8'h4f;
    tick(); tick();
    chk_all("single.pre", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd11);
    tick();
    chk_all("single.done", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 32'd12);

    // Masked compare: 8'h4f against 8'h40 with low nibble don't-care.
    do_reset();
    wr(2'd0, 8'h40, 8'h0F);
    obs = 8'h4f;
    arm(3'd1);
    n = 0;
    while (!pass && !fail && n < 200) begin tick(); n++; end
`ifdef IO_CHECK_MASK_EN
    chk("mask.latency", n, 32'd2);
    chk_all("mask", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 32'd2);
`else
    chk("nomask.latency", n, 32'd99);
    chk_all("nomask", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'd99);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
